// File: rtl/mem_access_unit.sv
// MEM pipeline stage: runs loads/stores on a single-outstanding req/ack bus,
// aligns load data, raises misalignment/timeout exceptions and registers MEM/WB.
module mem_access_unit #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] me_regs_data2,
   input  logic [31:0] me_alu_o,
   input  logic [4:0]  me_rd,
   input  logic        me_mem_read,
   input  logic        me_mem_write,
   input  logic        me_mem2reg,
   input  logic        me_regs_write,
   input  logic [2:0]  me_func3_code,
   input  logic [1:0]  me_priv_mode,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [31:0] dbus_addr,
   output logic [31:0] dbus_wdata,
   output logic [3:0]  dbus_be,
   output logic [1:0]  dbus_priv,
   input  logic        dbus_ack,
   input  logic [31:0] dbus_rdata,
   output logic        mem_stall,
   output logic [4:0]  wb_rd,
   output logic        wb_regs_write,
   output logic        wb_mem2reg,
   output logic [31:0] wb_alu_o,
   output logic [31:0] wb_mem_data,
   output logic        exc_valid,
   output logic [1:0]  exc_cause,
   output logic [31:0] exc_addr
);

   // state | meaning
   // IDLE  | no access in flight; pass-through or launch a bus request
   // BUSY  | request outstanding; waiting for dbus_ack or timeout
   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state, state_nxt;
   logic [7:0]  cnt;
   logic        acc, misaligned;
   logic        do_start, do_finish, do_fault, do_mis, do_pass;
   logic [3:0]  be_nxt;
   logic [31:0] wdata_nxt;
   logic [31:0] rd_shift;
   logic [31:0] load_data;

   assign acc = me_mem_read | me_mem_write;

   always_comb begin
      misaligned = 1'b0;
      case (me_func3_code)
         3'b000, 3'b100: misaligned = 1'b0;
         3'b001, 3'b101: misaligned = me_alu_o[0];
         3'b010:         misaligned = (me_alu_o[1:0] != 2'b00);
         default:        misaligned = 1'b1;
      endcase
   end

   always_comb begin
      be_nxt    = 4'b1111;
      wdata_nxt = me_regs_data2;
      case (me_func3_code[1:0])
         2'b00: begin
            be_nxt    = 4'b0001 << me_alu_o[1:0];
            wdata_nxt = {4{me_regs_data2[7:0]}};
         end
         2'b01: begin
            be_nxt    = 4'b0011 << me_alu_o[1:0];
            wdata_nxt = {2{me_regs_data2[15:0]}};
         end
         default: begin
            be_nxt    = 4'b1111;
            wdata_nxt = me_regs_data2;
         end
      endcase
   end

   assign rd_shift = dbus_rdata >> {me_alu_o[1:0], 3'b000};

   always_comb begin
      load_data = dbus_rdata;
      case (me_func3_code)
         3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
         3'b100:  load_data = {24'h0, rd_shift[7:0]};
         3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
         3'b101:  load_data = {16'h0, rd_shift[15:0]};
         default: load_data = dbus_rdata;
      endcase
   end

   // Nothing launches while reset is held, so all outputs read 0 in reset.
   always_comb begin
      state_nxt = state;
      mem_stall = 1'b0;
      do_start  = 1'b0;
      do_finish = 1'b0;
      do_fault  = 1'b0;
      do_mis    = 1'b0;
      do_pass   = 1'b0;
      if (rstn) begin
         case (state)
            IDLE: begin
               if (acc && !misaligned) begin
                  do_start  = 1'b1;
                  mem_stall = 1'b1;
                  state_nxt = BUSY;
               end else if (acc) begin
                  do_mis = 1'b1;
               end else begin
                  do_pass = 1'b1;
               end
            end
            BUSY: begin
               if (dbus_ack) begin
                  do_finish = 1'b1;
                  state_nxt = IDLE;
               end else if (cnt == CNT_LAST) begin
                  do_fault  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  mem_stall = 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state         <= IDLE;
         cnt           <= 8'd0;
         dbus_req      <= 1'b0;
         dbus_we       <= 1'b0;
         dbus_addr     <= 32'h0;
         dbus_wdata    <= 32'h0;
         dbus_be       <= 4'h0;
         dbus_priv     <= 2'b00;
         wb_rd         <= 5'd0;
         wb_regs_write <= 1'b0;
         wb_mem2reg    <= 1'b0;
         wb_alu_o      <= 32'h0;
         wb_mem_data   <= 32'h0;
         exc_valid     <= 1'b0;
         exc_cause     <= 2'b00;
         exc_addr      <= 32'h0;
      end else begin
         state     <= state_nxt;
         exc_valid <= 1'b0;
         if (mem_stall) wb_regs_write <= 1'b0;
         if (state == BUSY) cnt <= cnt + 8'd1;

         if (do_start) begin
            dbus_req   <= 1'b1;
            dbus_we    <= me_mem_write;
            dbus_addr  <= {me_alu_o[31:2], 2'b00};
            dbus_wdata <= wdata_nxt;
            dbus_be    <= be_nxt;
            dbus_priv  <= me_priv_mode;
            cnt        <= 8'd0;
         end

         if (do_pass || do_finish || do_mis) begin
            wb_rd         <= me_rd;
            wb_regs_write <= do_mis ? 1'b0 : me_regs_write;
            wb_mem2reg    <= me_mem2reg;
            wb_alu_o      <= me_alu_o;
            wb_mem_data   <= do_finish ? load_data : 32'h0;
         end

         if (do_finish || do_fault) begin
            dbus_req <= 1'b0;
            cnt      <= 8'd0;
         end

         if (do_mis) begin
            exc_valid <= 1'b1;
            exc_cause <= me_mem_read ? 2'b00 : 2'b01;
            exc_addr  <= me_alu_o;
         end

         if (do_fault) begin
            exc_valid     <= 1'b1;
            exc_cause     <= 2'b10;
            exc_addr      <= me_alu_o;
            wb_regs_write <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a short timeout (4 BUSY cycles).
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] me_regs_data2, me_alu_o;
   logic [4:0]  me_rd;
   logic        me_mem_read, me_mem_write, me_mem2reg, me_regs_write;
   logic [2:0]  me_func3_code;
   logic [1:0]  me_priv_mode;
   logic        dbus_req, dbus_we;
   logic [31:0] dbus_addr, dbus_wdata;
   logic [3:0]  dbus_be;
   logic [1:0]  dbus_priv;
   logic        dbus_ack;
   logic [31:0] dbus_rdata;
   logic        mem_stall;
   logic [4:0]  wb_rd;
   logic        wb_regs_write, wb_mem2reg;
   logic [31:0] wb_alu_o, wb_mem_data;
   logic        exc_valid;
   logic [1:0]  exc_cause;
   logic [31:0] exc_addr;

   int checks = 0;
   int errors = 0;
   int n;

   mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rstn(rstn),
      .me_regs_data2(me_regs_data2), .me_alu_o(me_alu_o), .me_rd(me_rd),
      .me_mem_read(me_mem_read), .me_mem_write(me_mem_write),
      .me_mem2reg(me_mem2reg), .me_regs_write(me_regs_write),
      .me_func3_code(me_func3_code), .me_priv_mode(me_priv_mode),
      .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
      .dbus_wdata(dbus_wdata), .dbus_be(dbus_be), .dbus_priv(dbus_priv),
      .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata), .mem_stall(mem_stall),
      .wb_rd(wb_rd), .wb_regs_write(wb_regs_write), .wb_mem2reg(wb_mem2reg),
      .wb_alu_o(wb_alu_o), .wb_mem_data(wb_mem_data),
      .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      #3;
   endtask

   task automatic set_op(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [4:0] rd, input logic rw, input logic m2r);
      me_mem_read   = rd_en;
      me_mem_write  = wr_en;
      me_func3_code = f3;
      me_alu_o      = addr;
      me_regs_data2 = rs2;
      me_rd         = rd;
      me_regs_write = rw;
      me_mem2reg    = m2r;
   endtask

   initial begin
      rstn = 1'b0; dbus_ack = 1'b0; dbus_rdata = 32'h0; me_priv_mode = 2'b11;
      set_op(0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0);
      tick(); tick();
      check("rst_req", 32'(dbus_req), 32'd0);
      check("rst_stall", 32'(mem_stall), 32'd0);
      check("rst_wb_rw", 32'(wb_regs_write), 32'd0);
      check("rst_exc", 32'(exc_valid), 32'd0);
      check("rst_wb_alu", wb_alu_o, 32'h0);
      rstn = 1'b1;

      // pass-through ADD
      set_op(0, 0, 3'b000, 32'h1234, 32'h0, 5'd5, 1, 0);
      mid(); check("pt_stall", 32'(mem_stall), 32'd0);
      tick();
      check("pt_alu", wb_alu_o, 32'h1234);
      check("pt_rd", 32'(wb_rd), 32'd5);
      check("pt_rw", 32'(wb_regs_write), 32'd1);

      // LB 0x1003, ack in first BUSY cycle
      set_op(1, 0, 3'b000, 32'h1003, 32'h0, 5'd7, 1, 1);
      mid(); check("lb_stall_idle", 32'(mem_stall), 32'd1);
      tick();
      check("lb_req", 32'(dbus_req), 32'd1);
      check("lb_be", 32'(dbus_be), 32'b1000);
      check("lb_addr", dbus_addr, 32'h1000);
      check("lb_we", 32'(dbus_we), 32'd0);
      check("lb_priv", 32'(dbus_priv), 32'd3);
      check("lb_bubble", 32'(wb_regs_write), 32'd0);
      dbus_ack = 1'b1; dbus_rdata = 32'h80FF_0011;
      mid(); check("lb_stall_ack", 32'(mem_stall), 32'd0);
      tick(); dbus_ack = 1'b0;
      check("lb_data", wb_mem_data, 32'hFFFF_FF80);
      check("lb_rw", 32'(wb_regs_write), 32'd1);
      check("lb_req_off", 32'(dbus_req), 32'd0);

      // LBU same address
      set_op(1, 0, 3'b100, 32'h1003, 32'h0, 5'd8, 1, 1);
      tick();
      dbus_ack = 1'b1;
      tick(); dbus_ack = 1'b0;
      check("lbu_data", wb_mem_data, 32'h0000_0080);
      check("lbu_rd", 32'(wb_rd), 32'd8);

      // SH 0x2002, ack in the 4th BUSY cycle (also ack beats timeout)
      set_op(0, 1, 3'b001, 32'h2002, 32'hAAAA_BEEF, 5'd0, 0, 0);
      n = 0;
      mid(); if (mem_stall) n++;
      tick();
      check("sh_we", 32'(dbus_we), 32'd1);
      check("sh_be", 32'(dbus_be), 32'b1100);
      check("sh_wdata", dbus_wdata, 32'hBEEF_BEEF);
      check("sh_addr", dbus_addr, 32'h2000);
      for (int i = 0; i < 3; i++) begin
         mid(); if (mem_stall) n++;
         tick();
      end
      dbus_ack = 1'b1;
      mid(); if (mem_stall) n++;
      check("sh_stall_cycles", 32'(n), 32'd4);
      tick(); dbus_ack = 1'b0;
      check("sh_no_exc", 32'(exc_valid), 32'd0);
      check("sh_req_off", 32'(dbus_req), 32'd0);
      check("sh_rw", 32'(wb_regs_write), 32'd0);

      // SB 0x3001 lanes
      set_op(0, 1, 3'b000, 32'h3001, 32'h1234_565A, 5'd0, 0, 0);
      tick();
      check("sb_be", 32'(dbus_be), 32'b0010);
      check("sb_wdata", dbus_wdata, 32'h5A5A_5A5A);
      dbus_ack = 1'b1;
      tick(); dbus_ack = 1'b0;

      // LW misaligned 0x0006
      set_op(1, 0, 3'b010, 32'h0006, 32'h0, 5'd9, 1, 1);
      mid();
      check("mis_stall", 32'(mem_stall), 32'd0);
      tick();
      check("mis_req", 32'(dbus_req), 32'd0);
      check("mis_exc", 32'(exc_valid), 32'd1);
      check("mis_cause", 32'(exc_cause), 32'd0);
      check("mis_addr", exc_addr, 32'h0006);
      check("mis_rw", 32'(wb_regs_write), 32'd0);
      set_op(0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0);
      tick();
      check("mis_pulse", 32'(exc_valid), 32'd0);

      // LW timeout at 0x0010
      set_op(1, 0, 3'b010, 32'h0010, 32'h0, 5'd10, 1, 1);
      tick();
      n = 0;
      for (int i = 0; i < 3; i++) begin
         mid(); if (dbus_req && mem_stall) n++;
         tick();
      end
      mid();
      check("to_stall_rel", 32'(mem_stall), 32'd0);
      if (dbus_req) n++;
      check("to_req_cycles", 32'(n), 32'd4);
      tick();
      set_op(0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0);
      check("to_exc", 32'(exc_valid), 32'd1);
      check("to_cause", 32'(exc_cause), 32'd2);
      check("to_addr", exc_addr, 32'h0010);
      check("to_rw", 32'(wb_regs_write), 32'd0);
      check("to_req_off", 32'(dbus_req), 32'd0);
      tick();
      check("to_pulse", 32'(exc_valid), 32'd0);

      // LW with ack in the 4th BUSY cycle
      set_op(1, 0, 3'b010, 32'h0020, 32'h0, 5'd11, 1, 1);
      tick(); tick(); tick(); tick();
      dbus_ack = 1'b1; dbus_rdata = 32'h1234_5678;
      tick(); dbus_ack = 1'b0;
      check("lw4_data", wb_mem_data, 32'h1234_5678);
      check("lw4_rw", 32'(wb_regs_write), 32'd1);
      check("lw4_no_exc", 32'(exc_valid), 32'd0);

      // reset during BUSY
      set_op(1, 0, 3'b001, 32'h0042, 32'h0, 5'd12, 1, 1);
      tick();
      check("rb_req", 32'(dbus_req), 32'd1);
      rstn = 1'b0;
      tick();
      check("rb_req_off", 32'(dbus_req), 32'd0);
      check("rb_stall", 32'(mem_stall), 32'd0);
      check("rb_wb_rd", 32'(wb_rd), 32'd0);
      check("rb_wb_data", wb_mem_data, 32'h0);
      check("rb_wb_alu", wb_alu_o, 32'h0);
      check("rb_exc", 32'(exc_valid), 32'd0);
      set_op(0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 0, 0);
      rstn = 1'b1;
      tick();
      check("rb_idle_req", 32'(dbus_req), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
